// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide scalar types.
package cpu_types_pkg;
  localparam int unsigned CPU_WORD_W = 32;
  typedef logic [CPU_WORD_W-1:0] word_t;
endpackage

// File: rtl/mem_arbiter_pkg.sv
// Types shared by the unified-RAM arbiter and its watchdog.
package mem_arbiter_pkg;
  typedef cpu_types_pkg::word_t word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } arb_state_t;
endpackage

// File: rtl/mem_arb_watchdog.sv
// Saturating access-age counter; expire_o is high once TIMEOUT-1 cycles have elapsed.
module mem_arb_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && (cnt_q != LAST))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q == LAST);
endmodule

// File: rtl/mem_arbiter.sv
// Unified-RAM arbiter: data side has priority, one IDLE cycle between accesses.
// Optional instruction-starvation guard enabled by MEM_ARB_FAIRNESS_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              ihit,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dhit,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              mem_err
);
  arb_state_t        state_q, state_d;
  logic [WORD_W-1:0] addr_q, addr_d, store_q, store_d;
  logic              wr_q, wr_d;
  ramstate_t         rs;
  logic              dreq, grant_d, grant_i, starved, expire, done, fail;

  assign rs      = ramstate_t'(ramstate);
  assign dreq    = dREN | dWEN;
  assign grant_d = (state_q == IDLE) && dreq && !starved;
  assign grant_i = (state_q == IDLE) && iREN && !grant_d;
  assign done    = (rs == ACCESS);
  // ACCESS arriving in the expiry cycle still wins over the timeout
  assign fail    = (rs == ERROR) || (expire && !done);

`ifdef MEM_ARB_FAIRNESS_EN
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_q, starve_d;

  assign starved = iREN && (starve_q == SW'(STARVE_MAX));

  always_comb begin
    starve_d = starve_q;
    if (grant_i)
      starve_d = '0;
    else if (grant_d && iREN)
      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) starve_q <= '0;
    else     starve_q <= starve_d;
  end
`else
  logic unused_starve_max;
  assign unused_starve_max = (STARVE_MAX == 0);
  assign starved           = 1'b0;
`endif

  mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk_i    (CLK),
    .rst_i    (RST),
    .clr_i    (state_q == IDLE),
    .en_i     (state_q != IDLE),
    .expire_o (expire)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    store_d  = store_q;
    wr_d     = wr_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    ihit     = 1'b0;
    dhit     = 1'b0;
    iload    = '0;
    dload    = '0;
    mem_err  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d = DACC;
          addr_d  = daddr;
          wr_d    = dWEN;
          store_d = dWEN ? dstore : '0;
        end else if (grant_i) begin
          state_d = IACC;
          addr_d  = iaddr;
          wr_d    = 1'b0;
          store_d = '0;
        end
      end
      IACC: begin
        ramREN  = 1'b1;
        ramaddr = addr_q;
        if (done) begin
          ihit    = iREN;
          iload   = iREN ? ramload : '0;
          state_d = IDLE;
        end else if (fail) begin
          mem_err = 1'b1;
          state_d = IDLE;
        end
      end
      DACC: begin
        ramREN   = !wr_q;
        ramWEN   = wr_q;
        ramaddr  = addr_q;
        ramstore = store_q;
        if (done) begin
          dhit    = dreq;
          dload   = dreq ? ramload : '0;
          state_d = IDLE;
        end else if (fail) begin
          mem_err = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      store_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      wr_q    <= wr_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int unsigned W   = 32;
  localparam int unsigned TO  = 8;
  localparam int unsigned SMX = 4;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [W-1:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  logic [1:0]   ramstate = 2'd0;
  logic         ihit, dhit, ramREN, ramWEN, mem_err;
  logic [W-1:0] iload, dload, ramaddr, ramstore;

  mem_arbiter #(.WORD_W(W), .TIMEOUT(TO), .STARVE_MAX(SMX)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .mem_err(mem_err)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 30)
        $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Reference model: one outstanding transaction plus the RAM's scripted reply.
  bit           m_busy = 0, m_isd = 0, m_wr = 0;
  logic [W-1:0] m_addr = '0, m_store = '0;
  int           m_age = 0, m_starve = 0;
  int           m_cnt = 0, m_mode = 0;   // mode 0: ACCESS, 1: ERROR, 2: never answers
  bit           fast_ram = 0;
  int           ihit_count = 0;

  task automatic cycle(input bit r, input bit ir, input bit dr, input bit dw,
                       input logic [W-1:0] ia, input logic [W-1:0] da, input logic [W-1:0] ds);
    bit done, err, e_ren, e_wen, e_ihit, e_dhit, e_err, fair;
    logic [W-1:0] e_addr, e_store, e_iload, e_dload;
    int rnd;
    @(posedge CLK);
    #1;
    RST = r; iREN = ir; dREN = dr; dWEN = dw;
    iaddr = ia; daddr = da; dstore = ds;
    ramload = $urandom;
    if (!m_busy)                           ramstate = 2'($urandom_range(0, 3));
    else if (m_mode == 2 || m_cnt > 0)     ramstate = 2'($urandom_range(0, 1));
    else                                   ramstate = (m_mode == 1) ? 2'd3 : 2'd2;
    #4;
    done = 0; err = 0;
    e_ren = 0; e_wen = 0; e_ihit = 0; e_dhit = 0; e_err = 0;
    e_addr = '0; e_store = '0; e_iload = '0; e_dload = '0;
    if (m_busy) begin
      done    = (ramstate == 2'd2);
      err     = (ramstate == 2'd3) || (!done && m_age == int'(TO) - 1);
      e_wen   = m_isd && m_wr;
      e_ren   = !e_wen;
      e_addr  = m_addr;
      e_store = e_wen ? m_store : '0;
      e_err   = err;
      if (done && !m_isd && iREN)          begin e_ihit = 1; e_iload = ramload; end
      if (done && m_isd && (dREN || dWEN)) begin e_dhit = 1; e_dload = ramload; end
    end
    check("ramREN",   ramREN,   e_ren);
    check("ramWEN",   ramWEN,   e_wen);
    check("ramaddr",  ramaddr,  e_addr);
    check("ramstore", ramstore, e_store);
    check("ihit",     ihit,     e_ihit);
    check("iload",    iload,    e_iload);
    check("dhit",     dhit,     e_dhit);
    check("dload",    dload,    e_dload);
    check("mem_err",  mem_err,  e_err);
    if (ihit === 1'b1) ihit_count++;

    if (RST) begin
      m_busy = 0; m_starve = 0;
    end else if (m_busy) begin
      if (done || err) m_busy = 0;
      else begin
        m_age++;
        if (m_cnt > 0) m_cnt--;
      end
    end else begin
`ifdef MEM_ARB_FAIRNESS_EN
      fair = iREN && (m_starve == int'(SMX));
`else
      fair = 0;
`endif
      if ((dREN || dWEN) && !fair) begin
        m_busy = 1; m_isd = 1; m_wr = dWEN; m_addr = daddr;
        m_store = dWEN ? dstore : '0;
        if (iREN) m_starve++;
      end else if (iREN) begin
        m_busy = 1; m_isd = 0; m_wr = 0; m_addr = iaddr; m_store = '0;
        m_starve = 0;
      end
      if (m_busy) begin
        m_age = 0;
        rnd = $urandom_range(0, 99);
        m_cnt  = fast_ram ? 0 : $urandom_range(0, 4);
        m_mode = fast_ram ? 0 : (rnd < 10 ? 1 : (rnd < 16 ? 2 : 0));
      end
    end
  endtask

  initial begin
    bit ir, dr, dw;
    logic [W-1:0] ia, da, ds;
    ir = 0; dr = 0; dw = 0; ia = '0; da = '0; ds = '0;

    repeat (3) cycle(1, 0, 0, 0, '0, '0, '0);

    // Requests flip with varying probability; occasional mid-access resets
    for (int unsigned ph = 0; ph < 4; ph++) begin
      for (int unsigned c = 0; c < 500; c++) begin
        if ($urandom_range(0, 99) < 10 + 15 * ph) ir = ~ir;
        if ($urandom_range(0, 99) < 10 + 10 * ph) dr = ~dr;
        if ($urandom_range(0, 99) < 8)            dw = ~dw;
        if ($urandom_range(0, 3) == 0) ia = $urandom & 32'hFFFC;
        if ($urandom_range(0, 3) == 0) da = $urandom & 32'hFFFC;
        ds = $urandom;
        cycle($urandom_range(0, 59) == 0, ir, dr, dw, ia, da, ds);
      end
    end

    // Continuous data reads competing with a continuous fetch, RAM always ready
    fast_ram = 1;
    repeat (2) cycle(1, 0, 0, 0, '0, '0, '0);
    ihit_count = 0;
    for (int unsigned c = 0; c < 100; c++)
      cycle(0, 1, 1, 0, 32'h100, 32'h40 + 4 * c, '0);
`ifdef MEM_ARB_FAIRNESS_EN
    check("fairness_ihits", ihit_count, 10);
`else
    check("strict_ihits", ihit_count, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Sequences the single-ported unified RAM between instruction fetch and the pipeline's data memory stage.
- Grants one requester per access.
- Latches that requester's address and store data.
- Waits out variable RAM latency, then returns a one-cycle hit plus load data.
- Data requests take priority because the memory stage stalls the whole pipeline. A watchdog aborts hung accesses.

Parameters:
WORD_W, 32, address and data width
TIMEOUT, 64, cycles in an access state without ACCESS before abort (>=2)
STARVE_MAX, 4, consecutive data grants with iREN pending before a forced instruction grant (used only with the optional feature)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, synchronous, active-high
iREN  in  1  instruction fetch request
iaddr  in  WORD_W  fetch address
ihit  out  1  fetch complete (one cycle)
iload  out  WORD_W  fetch data, valid with ihit
dREN  in  1  data read request
dWEN  in  1  data write request
daddr  in  WORD_W  data address
dstore  in  WORD_W  write data
dhit  out  1  data access complete (one cycle)
dload  out  WORD_W  read data, valid with dhit
ramREN  out  1  RAM read strobe
ramWEN  out  1  RAM write strobe
ramaddr  out  WORD_W  RAM address
ramstore  out  WORD_W  RAM write data
ramload  in  WORD_W  RAM read data
ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3
mem_err  out  1  one-cycle pulse on RAM ERROR or timeout

Behaviour:
- States: IDLE, IACC, DACC.
- RST (synchronous) forces IDLE, clears latched address/data, watchdog and starve counter. All outputs are 0 while in IDLE with no access in flight.
- IDLE:
  - (dREN|dWEN) -> DACC.
  - else iREN -> IACC.
  - else stay.
  - On the transition, latch the address; for a write, also latch dstore and the write flag.
  - dWEN and dREN both high: treated as a write.
- IACC: ramREN=1, ramaddr=latched iaddr.
- DACC: ramREN=~wr, ramWEN=wr, ramaddr/ramstore from latches.
- RAM strobes are driven only in IACC/DACC and never change mid-access, even if the requester's inputs change.
- Completion: ramstate==ACCESS in IACC/DACC.
  - Same cycle: ihit/dhit = 1, gated by the requester's REN/WEN still being high; iload/dload = ramload (combinational).
  - Next state IDLE.
  - If the requester has dropped its request (e.g. fetch flush), the RAM access still completes but the hit is suppressed.
- Latency: request seen at cycle t -> strobes at t+1 -> earliest hit at t+1. There is always one IDLE cycle between accesses, so back-to-back throughput is 1 access per 2 cycles.
- ERROR in IACC/DACC: mem_err pulses, no hit, return to IDLE. The held request is re-arbitrated, which acts as a retry.
- Watchdog:
  - Counts cycles in IACC/DACC and clears in IDLE.
  - Reaching TIMEOUT-1 without ACCESS: mem_err pulses, strobes drop, state goes to IDLE.
- ihit and dhit are never asserted in the same cycle.
- iload/dload are 0 when not hitting.

Optional Feature:
MEM_ARB_FAIRNESS_EN
- Defined:
  - A starve counter increments on each data grant made while iREN is high, and clears on any instruction grant.
  - When it equals STARVE_MAX and iREN is high, IDLE grants the instruction side even if a data request is pending.
- Undefined: strict data priority; the counter is not instantiated.

Decomposition:
- Shared package:
  - ramstate_t enum (FREE/BUSY/ACCESS/ERROR);
  - arb_state_t enum (IDLE/IACC/DACC);
  - word_t, reused from cpu_types_pkg.
- Sub-module mem_arb_watchdog: a saturating counter with clear/enable inputs and a TIMEOUT-parameterised expire output.

Test Plan:
- iREN=1, iaddr=0x100, RAM gives ACCESS 3 cycles after ramREN with ramload=0xDEADBEEF -> ramaddr=0x100 from t+1; ihit=1 and iload=0xDEADBEEF for exactly one cycle; no dhit.
- iREN and dWEN asserted together, daddr=0x200, dstore=0x1234 -> ramWEN with ramaddr=0x200 and ramstore=0x1234 first; dhit, then one IDLE cycle, then ramREN at iaddr, then ihit.
- Fetch granted, iREN dropped before ACCESS -> access completes; ihit stays 0; state returns to IDLE; no stale data.
- RAM answers ERROR on a dREN read at 0x40 -> mem_err pulses one cycle; no dhit; next cycle IDLE, then re-grant of 0x40.
- RAM held BUSY forever -> mem_err after TIMEOUT cycles; strobes 0; new requests are served afterwards.
- With MEM_ARB_FAIRNESS_EN and STARVE_MAX=4: continuous dREN plus iREN -> exactly one instruction grant after every 4 data grants. Without the macro: no ihit while dREN is held.
- RST asserted mid-DACC -> next edge: IDLE; all RAM strobes, hits and mem_err at 0.
